// File: rtl/multicycle_alu.sv
// Registered ALU for the multi-cycle datapath: single-cycle ops finish one cycle after issue,
// MUL runs a WIDTH-iteration shift-add loop and returns the full 2*WIDTH product.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             ovf_o
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_MUL = 4'b1011;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_accHi, r_accLo;
  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_done, r_zero, r_ovf;

  logic             w_accept, w_isMul, w_mulDone;
  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic             w_zero, w_ovf;
  logic [WIDTH:0]   w_step;

  assign ready_o   = (r_state == S_IDLE);
  assign w_accept  = valid_i & ready_o;
  assign w_isMul   = (ctrl_i == OP_MUL);
  // The counter runs one past the last iteration so the product is published on the following edge.
  assign w_mulDone = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_isMul) w_next = S_MUL;
      S_MUL:   if (w_mulDone) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sum  = src1_i + src2_i;
  assign w_diff = src1_i - src2_i;

  always_comb begin
    w_res  = '0;
    w_zero = 1'b0;
    w_ovf  = 1'b0;
    case (ctrl_i)
      4'b0000: w_res = src1_i & src2_i;
      4'b0001: w_res = src1_i | src2_i;
      4'b0010: begin
        w_res = w_sum;
        w_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      4'b0110, 4'b1001: begin
        w_res = w_diff;
        w_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (w_diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      4'b1111: w_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      4'b1100: w_res = ~(src1_i | src2_i);
      4'b1101: w_zero = src1_i[WIDTH-1] | (src1_i == '0);
      default: w_res = '0;
    endcase
    // Unknown codes leave w_res at zero, so this also yields their required zero_o=1.
    if (ctrl_i != 4'b1101) w_zero = (w_res == '0);
  end

  assign w_step = {1'b0, r_accHi} + {1'b0, r_mcand & {WIDTH{r_mplier[0]}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_accHi  <= '0;
      r_accLo  <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept && w_isMul) begin
          r_mcand  <= src1_i;
          r_mplier <= src2_i;
          r_accHi  <= '0;
          r_accLo  <= '0;
          r_cnt    <= '0;
        end else if (w_accept) begin
          r_result <= w_res;
          r_hi     <= '0;
          r_zero   <= w_zero;
          r_ovf    <= w_ovf;
          r_done   <= 1'b1;
        end
      end else if (w_mulDone) begin
        r_result <= r_accLo;
        r_hi     <= r_accHi;
        r_zero   <= (r_accLo == '0);
        r_ovf    <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        r_accHi  <= w_step[WIDTH:1];
        r_accLo  <= {w_step[0], r_accLo[WIDTH-1:1]};
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign done_o   = r_done;
  assign result_o = r_result;
  assign hi_o     = r_hi;
  assign zero_o   = r_zero;
  assign ovf_o    = r_ovf;

endmodule
